uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Captures each byte the receiver delivers (single-cycle rx_valid pulse with rx_data) into a circular buffer.
- Presents bytes to the consumer through a first-word-fall-through valid/ready read port.
- Decouples the bursty serial byte stream from a consumer that cannot react on every cycle, and reports overrun.

---
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular byte store with a
// first-word-fall-through read port and sticky overrun reporting.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_MEM    = 2'd1,
    SRC_BYPASS = 2'd2
  } src_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_q;

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [CW-1:0]    avail;
  logic             overflow_reg, overflow_next;
  logic [7:0]       drop_reg, drop_next;
  src_t             src_reg, src_next;
  logic [WIDTH-1:0] bypass_reg, bypass_next;

  logic push;
  logic pop;
  logic drop;

  // Flags depend on the count register only, never on the inputs.
  assign full       = (count_reg == DEPTH_C);
  assign empty      = (count_reg == '0);
  assign rd_valid   = ~empty;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_reg;

  assign pop  = rd_valid & rd_ready;
  assign push = rx_valid & (~full | pop);
  assign drop = rx_valid & full & ~pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // The head for next cycle comes from storage unless the entry is only
  // being written on this edge, in which case rx_data is captured directly.
  always_comb begin
    avail       = count_reg - CW'(pop);
    src_next    = SRC_ZERO;
    bypass_next = bypass_reg;
    if (avail != '0) begin
      src_next = SRC_MEM;
    end else if (push) begin
      src_next    = SRC_BYPASS;
      bypass_next = rx_data;
    end
  end

  // A drop on the same edge as a clear leaves exactly that one drop recorded.
  always_comb begin
    overflow_next = overflow_reg;
    drop_next     = drop_reg;
    if (drop) begin
      overflow_next = 1'b1;
      if (overflow_clr) begin
        drop_next = 8'd1;
      end else if (drop_reg != 8'hFF) begin
        drop_next = drop_reg + 8'd1;
      end
    end else if (overflow_clr) begin
      overflow_next = 1'b0;
      drop_next     = 8'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= 8'd0;
      src_reg      <= SRC_ZERO;
      bypass_reg   <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      drop_reg     <= drop_next;
      src_reg      <= src_next;
      bypass_reg   <= bypass_next;
    end
  end

  // Storage has no reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clock) begin
    if (push && rst) begin
      mem[wr_ptr_reg] <= rx_data;
    end
    mem_q <= mem[rd_ptr_next];
  end

  always_comb begin
    case (src_reg)
      SRC_MEM:    rd_data = mem_q;
      SRC_BYPASS: rd_data = bypass_reg;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_valid = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [4:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             overflow_clr = 1'b0;
  logic [7:0]       drop_count;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of bytes plus the overrun bookkeeping.
  logic [7:0] q[$];
  logic       m_ov = 1'b0;
  int         m_drops = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .overflow_clr(overflow_clr),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check(input string name);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({name, ".count"}, 32'(count), 32'(q.size()));
    chk({name, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    chk({name, ".rd_data"}, 32'(rd_data), 32'(head));
    chk({name, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({name, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({name, ".overflow"}, 32'(overflow), 32'(m_ov));
    chk({name, ".drop_count"}, 32'(drop_count), 32'(m_drops));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic rr, input logic c, input string name);
    bit mfull, mpop, mpush, mdrop;
    rst = r; rx_valid = v; rx_data = d; rd_ready = rr; overflow_clr = c;
    if (!r) begin
      q.delete();
      m_ov = 1'b0;
      m_drops = 0;
    end else begin
      mfull = (q.size() == DEPTH);
      mpop  = (q.size() != 0) && rr;
      mpush = v && (!mfull || mpop);
      mdrop = v && mfull && !mpop;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(d);
      if (mdrop) begin
        m_ov = 1'b1;
        m_drops = c ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (c) begin
        m_ov = 1'b0;
        m_drops = 0;
      end
    end
    @(posedge clock);
    #1;
    model_check(name);
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       rr;
    logic       c;
    logic [4:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ov;
    logic [7:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic rr, logic c,
                              logic [4:0] ec, logic ev, logic [7:0] ed,
                              logic eo, logic [7:0] edr);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.rr = rr; t.c = c;
    t.e_count = ec; t.e_valid = ev; t.e_data = ed; t.e_ov = eo; t.e_drop = edr;
    return t;
  endfunction

  initial begin
    int n;
    int head;
    int max_cnt;

    // Reset, single byte held, pop, and simultaneous push/pop on small occupancy.
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 8'h3C, 1, 0, 1, 1, 8'h3C, 0, 0));
    tbl.push_back(mk(1, 1, 8'h7E, 1, 0, 1, 1, 8'h7E, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].c, "tbl");
      chk("tbl.count", 32'(count), 32'(tbl[i].e_count));
      chk("tbl.rd_valid", 32'(rd_valid), 32'(tbl[i].e_valid));
      chk("tbl.rd_data", 32'(rd_data), 32'(tbl[i].e_data));
      chk("tbl.overflow", 32'(overflow), 32'(tbl[i].e_ov));
      chk("tbl.drop_count", 32'(drop_count), 32'(tbl[i].e_drop));
      $display("[TB] vec %0d: count=%0d rd_valid=%b rd_data=%02h overflow=%b drops=%0d",
               i, count, rd_valid, rd_data, overflow, drop_count);
    end

    // Fill and overrun.
    for (int i = 0; i < 16; i++) step(1, 1, 8'(i), 0, 0, "fill");
    step(1, 1, 8'h10, 0, 0, "ovr");
    step(1, 1, 8'h11, 0, 0, "ovr");
    chk("ovr.full", 32'(full), 32'd1);
    chk("ovr.count", 32'(count), 32'd16);
    chk("ovr.overflow", 32'(overflow), 32'd1);
    chk("ovr.drop_count", 32'(drop_count), 32'd2);
    $display("[TB] fill/overrun: count=%0d overflow=%b drops=%0d", count, overflow, drop_count);
    for (int i = 0; i < 16; i++) begin
      chk("drain.data", 32'(rd_data), 32'(i));
      step(1, 0, 8'h00, 1, 0, "drain");
    end
    chk("drain.empty", 32'(empty), 32'd1);
    $display("[TB] drain after overrun: empty=%b", empty);

    // Push and pop on the same edge while full.
    step(1, 0, 8'h00, 0, 1, "clr");
    chk("clr.overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h20 + i), 0, 0, "fill2");
    step(1, 1, 8'h55, 1, 0, "fullpp");
    chk("fullpp.count", 32'(count), 32'd16);
    chk("fullpp.overflow", 32'(overflow), 32'd0);
    $display("[TB] full push+pop: count=%0d overflow=%b", count, overflow);
    for (int i = 0; i < 16; i++) begin
      chk("drain2.data", 32'(rd_data), (i == 15) ? 32'h55 : 32'(8'h21 + i));
      step(1, 0, 8'h00, 1, 0, "drain2");
    end
    chk("drain2.empty", 32'(empty), 32'd1);

    // Wrap-around with occupancy held at 3.
    n = 0;
    head = 0;
    max_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'(n), 0, 0, "wrap.pre");
      n++;
    end
    for (int i = 0; i < 40; i++) begin
      chk("wrap.data", 32'(rd_data), 32'(head & 8'hFF));
      step(1, 1, 8'(n), 1, 0, "wrap");
      n++;
      head++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("wrap.count", 32'(count), 32'd3);
    chk("wrap.max_le_4", 32'(max_cnt <= 4), 32'd1);
    $display("[TB] wrap: 40 push/pop pairs, head now %02h", rd_data);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0, "wrap.drain");

    // Clear colliding with a drop, then saturation, then reset mid-fill.
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h40 + i), 0, 0, "fill3");
    for (int i = 0; i < 5; i++) step(1, 1, 8'hEE, 0, 0, "drop5");
    chk("drop5.overflow", 32'(overflow), 32'd1);
    chk("drop5.drop_count", 32'(drop_count), 32'd5);
    step(1, 1, 8'h99, 0, 1, "clrdrop");
    chk("clrdrop.overflow", 32'(overflow), 32'd1);
    chk("clrdrop.drop_count", 32'(drop_count), 32'd1);
    $display("[TB] clear+drop: overflow=%b drops=%0d", overflow, drop_count);
    step(1, 0, 8'h00, 0, 1, "clronly");
    chk("clronly.overflow", 32'(overflow), 32'd0);
    chk("clronly.drop_count", 32'(drop_count), 32'd0);
    for (int i = 0; i < 300; i++) step(1, 1, 8'hDD, 0, 0, "sat");
    chk("sat.drop_count", 32'(drop_count), 32'd255);
    $display("[TB] saturation: drops=%0d", drop_count);
    step(0, 0, 8'h00, 0, 0, "rst1");
    for (int i = 0; i < 7; i++) step(1, 1, 8'(8'h70 + i), 0, 0, "fill7");
    chk("fill7.count", 32'(count), 32'd7);
    step(0, 1, 8'hAB, 0, 0, "rst7");
    chk("rst7.count", 32'(count), 32'd0);
    chk("rst7.empty", 32'(empty), 32'd1);
    chk("rst7.rd_data", 32'(rd_data), 32'd0);
    step(1, 0, 8'h00, 0, 0, "post_rst");
    chk("post_rst.count", 32'(count), 32'd0);
    $display("[TB] reset at count 7: count=%0d empty=%b", count, empty);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 99) < 55),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 49) == 0),
           "rand");
    end
    $display("[TB] random: 3000 cycles, final count=%0d", count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
